// File: rtl/seg_shift_ctrl.sv
// ----------------------------------------------------------------------------
// seg_shift_ctrl
//   Sequencer for the board's serial 7-segment shift chain. A segment image
//   is captured on an accepted start, shifted out MSB-first on a divided
//   serial clock (seg_clk), and the display is then re-enabled (seg_pen) and
//   done is pulsed for one cycle.
//
// Parameters
//   DATA_W       width of the segment image / bits shifted per transfer
//   DIV          clk cycles per seg_clk phase (low and high each), 1..255
//   REFRESH_CYC  idle cycles between automatic retransmissions, >= 2
//                (only with SEG_AUTO_REFRESH_EN)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   start     in   transfer request, sampled only while busy=0
//   data      in   segment image, captured on the accepted start edge
//   busy      out  high while a transfer is in progress (incl. latch cycle)
//   done      out  one-cycle pulse at the end of a transfer
//   seg_clk   out  serial clock; chain samples on its rising edge
//   seg_sout  out  serial data, stable across each seg_clk rising edge
//   seg_pen   out  display enable; 0 while shifting, 1 after completion
//   seg_clrn  out  active-low chain clear; low during rst and one cycle after
//
// Optional feature (macro SEG_AUTO_REFRESH_EN)
//   When defined, an idle counter retransmits the last captured image every
//   REFRESH_CYC idle cycles. An external start in the same cycle wins.
// ----------------------------------------------------------------------------
module seg_shift_ctrl #(
  parameter int DATA_W      = 64,
  parameter int DIV         = 2,
  parameter int REFRESH_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              seg_clk,
  output logic              seg_sout,
  output logic              seg_pen,
  output logic              seg_clrn
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  shift_reg;
  logic [DATA_W-1:0]  shift_nxt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [7:0]         phase_cnt;
  logic               clrn_q;     // first stage of the post-reset clear stretch
  logic               load_go;
  logic [DATA_W-1:0]  load_val;
  logic               phase_end;

`ifdef SEG_AUTO_REFRESH_EN
  localparam int IDLE_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  logic [DATA_W-1:0]  shadow_reg;
  logic [IDLE_W-1:0]  idle_cnt;
`endif

  assign shift_nxt = shift_reg << 1;
  assign phase_end = (phase_cnt == 8'(DIV - 1));

  // Decide whether a transfer begins this cycle and which image it carries.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned; otherwise a latch is inferred.
  always_comb begin
    load_go  = 1'b0;
    load_val = data;
    if (state == IDLE) begin
      if (start) begin
        load_go = 1'b1;
`ifdef SEG_AUTO_REFRESH_EN
      end else if (idle_cnt == IDLE_W'(REFRESH_CYC - 1)) begin
        load_go  = 1'b1;
        load_val = shadow_reg;
`endif
      end
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift/data registers are reset too, so a reset always
      // leaves seg_sout at a known 0 and no stale image survives.
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_clk   <= 1'b0;
      seg_sout  <= 1'b0;
      seg_pen   <= 1'b0;
      clrn_q    <= 1'b0;
      seg_clrn  <= 1'b0;
`ifdef SEG_AUTO_REFRESH_EN
      shadow_reg <= '0;
      idle_cnt   <= '0;
`endif
    end else begin
      // Two-stage release keeps the chain cleared one cycle past reset.
      clrn_q   <= 1'b1;
      seg_clrn <= clrn_q;
      done     <= 1'b0;

      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (load_go) begin
            shift_reg <= load_val;
            bit_cnt   <= CNT_W'(DATA_W - 1);
            phase_cnt <= '0;
            seg_pen   <= 1'b0;
            busy      <= 1'b1;
            seg_clk   <= 1'b0;
            seg_sout  <= load_val[DATA_W-1];
            state     <= SHIFT_LO;
`ifdef SEG_AUTO_REFRESH_EN
            shadow_reg <= load_val;
            idle_cnt   <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
`endif
          end
        end

        SHIFT_LO: begin
          if (phase_end) begin
            phase_cnt <= '0;
            seg_clk   <= 1'b1;
            state     <= SHIFT_HI;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        SHIFT_HI: begin
          if (phase_end) begin
            phase_cnt <= '0;
            seg_clk   <= 1'b0;
            if (bit_cnt == '0) begin
              done  <= 1'b1;
              state <= LATCH;
            end else begin
              // Next bit is presented together with the falling seg_clk so it
              // has a full low phase of setup before the next rising edge.
              shift_reg <= shift_nxt;
              seg_sout  <= shift_nxt[DATA_W-1];
              bit_cnt   <= bit_cnt - 1'b1;
              state     <= SHIFT_LO;
            end
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        LATCH: begin
          busy    <= 1'b0;
          seg_pen <= 1'b1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_shift_ctrl.sv
module tb_seg_shift_ctrl;

`ifdef SEG_AUTO_REFRESH_EN
  localparam int NDUT = 3;
`else
  localparam int NDUT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data = '0;
  logic [2:0]  start_v = '0;
  logic [2:0]  busy_v, done_v, sclk_v, sout_v, pen_v, clrn_v;
  logic [2:0]  mon_en = 3'b011;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int done_cnt [3] = '{0, 0, 0};
  logic [63:0] exp_q [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut 0: DIV=1, dut 1: DIV=2, dut 2: DIV=1 with a short refresh period
  seg_shift_ctrl #(.DATA_W(64), .DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .data(data),
    .busy(busy_v[0]), .done(done_v[0]), .seg_clk(sclk_v[0]),
    .seg_sout(sout_v[0]), .seg_pen(pen_v[0]), .seg_clrn(clrn_v[0]));

  seg_shift_ctrl #(.DATA_W(64), .DIV(2)) u_d2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .data(data),
    .busy(busy_v[1]), .done(done_v[1]), .seg_clk(sclk_v[1]),
    .seg_sout(sout_v[1]), .seg_pen(pen_v[1]), .seg_clrn(clrn_v[1]));

`ifdef SEG_AUTO_REFRESH_EN
  seg_shift_ctrl #(.DATA_W(64), .DIV(1), .REFRESH_CYC(8)) u_ar (
    .clk(clk), .rst(rst), .start(start_v[2]), .data(data),
    .busy(busy_v[2]), .done(done_v[2]), .seg_clk(sclk_v[2]),
    .seg_sout(sout_v[2]), .seg_pen(pen_v[2]), .seg_clrn(clrn_v[2]));
`else
  assign busy_v[2] = 1'b0;
  assign done_v[2] = 1'b0;
  assign sclk_v[2] = 1'b0;
  assign sout_v[2] = 1'b0;
  assign pen_v[2]  = 1'b0;
  assign clrn_v[2] = 1'b0;
`endif

  function automatic int div_of(input int g);
    return (g == 1) ? 2 : 1;
  endfunction

  // Per-DUT monitor: models the external shift register (captures seg_sout on
  // each seg_clk rising edge), checks phase lengths and data hold, and on
  // each done pops the scoreboard entry pushed when the start was driven.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    logic [63:0] cap;
    logic [63:0] exp_img;
    int          nbits;
    int          run;
    logic        pclk, pbusy, psout;

    always @(negedge clk) begin
      if (rst || !mon_en[g]) begin
        cap = '0; nbits = 0; run = 0; pclk = 1'b0; pbusy = 1'b0; psout = 1'b0;
      end else begin
        if (busy_v[g]) begin
          if (!pbusy || sclk_v[g] !== pclk) begin
            if (pbusy) begin
              tests_run++;
              if (run !== div_of(g)) begin
                tests_failed++;
                $display("FAIL phase_len dut%0d: phase lasted %0d cycles, required %0d", g, run, div_of(g));
              end
            end
            run = 1;
          end else begin
            run++;
          end
          if (sclk_v[g] && !pclk) begin
            cap = {cap[62:0], sout_v[g]};
            nbits++;
          end
          if (sclk_v[g] && pclk) begin
            tests_run++;
            if (sout_v[g] !== psout) begin
              tests_failed++;
              $display("FAIL sout_hold dut%0d: sout changed to %b during seg_clk high, required %b", g, sout_v[g], psout);
            end
          end
        end else begin
          run = 0;
        end
        if (done_v[g]) begin
          done_cnt[g]++;
          tests_run++;
          if (exp_q[g].size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_done dut%0d: done with image %h, no transfer expected", g, cap);
          end else begin
            exp_img = exp_q[g].pop_front();
            if (cap !== exp_img || nbits !== 64) begin
              tests_failed++;
              $display("FAIL image dut%0d: captured %h (%0d bits), required %h (64 bits)", g, cap, nbits, exp_img);
            end
          end
          cap = '0;
          nbits = 0;
        end
        pclk  = sclk_v[g];
        pbusy = busy_v[g];
        psout = sout_v[g];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_xfer(input int g, input logic [63:0] d);
    data = d;
    exp_q[g].push_back(d);
    start_v[g] = 1'b1;
    tick();
    start_v[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_v[g]) begin
        ok = 1;
        return;
      end
    end
    tests_run++;
    tests_failed++;
    $display("FAIL done_timeout dut%0d: no done within %0d cycles", g, budget);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      for (int g = 0; g < NDUT; g++) begin
        tests_run++;
        if ({busy_v[g], done_v[g], sclk_v[g], sout_v[g], pen_v[g], clrn_v[g]} !== 6'b0) begin
          tests_failed++;
          $display("FAIL reset_vals dut%0d: {busy,done,clk,sout,pen,clrn}=%b, required 000000",
                   g, {busy_v[g], done_v[g], sclk_v[g], sout_v[g], pen_v[g], clrn_v[g]});
        end
      end
    end
    rst = 1'b0;
    tick();
    for (int g = 0; g < NDUT; g++) begin
      tests_run++;
      if (clrn_v[g] !== 1'b0) begin
        tests_failed++;
        $display("FAIL clrn_hold dut%0d: seg_clrn=%b one cycle after reset, required 0", g, clrn_v[g]);
      end
    end
    tick();
    for (int g = 0; g < NDUT; g++) begin
      tests_run++;
      if (clrn_v[g] !== 1'b1) begin
        tests_failed++;
        $display("FAIL clrn_release dut%0d: seg_clrn=%b two cycles after reset, required 1", g, clrn_v[g]);
      end
    end
  endtask

  task automatic test_reset();
    int dc;
    apply_reset(3);
    dc = done_cnt[0];
    start_xfer(0, 64'hDEAD_BEEF_0123_4567);
    repeat (20) tick();
    apply_reset(3);
    exp_q[0].delete();
    tests_run++;
    if (done_cnt[0] !== dc) begin
      tests_failed++;
      $display("FAIL reset_no_done: %0d done pulses after abort, required 0", done_cnt[0] - dc);
    end
  endtask

  task automatic test_single();
    int t0, ok;
    t0 = cyc;
    start_xfer(0, 64'h8000_0000_0000_0001);
    wait_done(0, 300, ok);
    if (ok != 0) begin
      tests_run++;
      if (cyc !== t0 + 1 + 2 * 1 * 64) begin
        tests_failed++;
        $display("FAIL single_latency: done at cycle +%0d, required +%0d", cyc - t0, 1 + 128);
      end
      tests_run++;
      if (pen_v[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_pen_done: seg_pen=%b in done cycle, required 0", pen_v[0]);
      end
      tick();
      tests_run++;
      if (pen_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_after: pen=%b busy=%b, required pen=1 busy=0", pen_v[0], busy_v[0]);
      end
    end
  endtask

  task automatic test_bit_order();
    int t0, ok;
    t0 = cyc;
    start_xfer(1, 64'hA5A5_F00F_0123_4567);
    wait_done(1, 600, ok);
    if (ok != 0) begin
      tests_run++;
      if (cyc !== t0 + 1 + 2 * 2 * 64) begin
        tests_failed++;
        $display("FAIL order_latency: done at cycle +%0d, required +%0d", cyc - t0, 1 + 256);
      end
    end
    tick();
  endtask

  task automatic test_busy();
    int dc, ok;
    dc = done_cnt[0];
    start_xfer(0, 64'h0);
    repeat (9) tick();
    data = '1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    wait_done(0, 300, ok);
    // Request during the latch cycle must be dropped.
    data = '1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (busy_v[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL busy_ignore: busy=%b %0d cycles after done, required 0", busy_v[0], i + 1);
      end
      tick();
    end
    tests_run++;
    if (done_cnt[0] - dc !== 1) begin
      tests_failed++;
      $display("FAIL busy_done_count: %0d done pulses, required 1", done_cnt[0] - dc);
    end
  endtask

  task automatic test_back_to_back();
    int ok;
    exp_q[0].push_back(64'h0F0F_1234_5678_9ABC);
    exp_q[0].push_back(64'hFEDC_BA98_7654_3210);
    data = 64'h0F0F_1234_5678_9ABC;
    start_v[0] = 1'b1;
    tick();
    data = 64'hFEDC_BA98_7654_3210;
    wait_done(0, 300, ok);
    tick();
    tests_run++;
    if (busy_v[0] !== 1'b0 || pen_v[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_gap: busy=%b pen=%b in gap cycle, required busy=0 pen=1", busy_v[0], pen_v[0]);
    end
    tick();
    tests_run++;
    if (busy_v[0] !== 1'b1 || pen_v[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_second: busy=%b pen=%b, required busy=1 pen=0", busy_v[0], pen_v[0]);
    end
    start_v[0] = 1'b0;
    wait_done(0, 300, ok);
    tick();
    tick();
    tests_run++;
    if (busy_v[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: busy=%b after second transfer, required 0", busy_v[0]);
    end
  endtask

`ifdef SEG_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    int ok, n;
    mon_en[2] = 1'b0;
    apply_reset(1);
    mon_en[2] = 1'b1;
    start_xfer(2, 64'h1234);
    wait_done(2, 300, ok);
    exp_q[2].push_back(64'h1234);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy_v[2]) break;
      n++;
    end
    tests_run++;
    if (n !== 8) begin
      tests_failed++;
      $display("FAIL auto_interval: %0d idle cycles before refresh, required 8", n);
    end
    wait_done(2, 300, ok);
    exp_q[2].push_back(64'h5678);
    repeat (8) tick();
    tests_run++;
    if (busy_v[2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL auto_pre_expiry: busy=%b in 8th idle cycle, required 0", busy_v[2]);
    end
    data = 64'h5678;
    start_v[2] = 1'b1;
    tick();
    start_v[2] = 1'b0;
    tests_run++;
    if (busy_v[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL auto_ext_start: busy=%b after expiry-cycle start, required 1", busy_v[2]);
    end
    wait_done(2, 300, ok);
    mon_en[2] = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_bit_order();
    test_busy();
    test_back_to_back();
`ifdef SEG_AUTO_REFRESH_EN
    test_auto_refresh();
`endif
    repeat (2) tick();
    for (int g = 0; g < 2; g++) begin
      tests_run++;
      if (exp_q[g].size() != 0) begin
        tests_failed++;
        $display("FAIL leftover dut%0d: %0d expected transfers never completed, required 0", g, exp_q[g].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
